// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: device-side command endpoint behind a UART PHY.
// Decodes register write (0x57,addr,data -> 0x4B) and read (0x52,addr -> value)
// packets, drives a simple register port and returns the response byte(s)
// through a valid/ready transmit handshake.
// Optional feature macro: UART_CMD_RESP_CHECKSUM_EN adds a trailing XOR checksum
// byte per command and a two-byte read response.
// Handshake: a response byte transfers on a rising edge where tx_vld && tx_rdy;
// tx_vld and tx_data stay stable until then, and tx_vld never drops early.
module uart_cmd_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int TIMEOUT_CLKS = 480000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   input  logic                 tx_rdy,
   output logic                 tx_vld,
   output logic [7:0]           tx_data,
   output logic [ADDR_BITS-1:0] reg_addr,
   output logic                 reg_wr_en,
   output logic [7:0]           reg_wr_data,
   output logic                 reg_rd_en,
   input  logic [7:0]           reg_rd_data,
   output logic                 busy,
   output logic                 err_timeout,
   output logic                 err_overrun
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_BAD  = 8'h3F;
`ifdef UART_CMD_RESP_CHECKSUM_EN
   localparam logic [7:0] RSP_CSUM = 8'h21;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_ADDR = 3'd1,
      S_GET_DATA = 3'd2,
      S_READ     = 3'd3,
      S_CAPTURE  = 3'd4,
      S_SEND     = 3'd5
`ifdef UART_CMD_RESP_CHECKSUM_EN
      , S_GET_CSUM = 3'd6
`endif
   } state_t;

   state_t        state;
   logic          is_write;
   logic [TW-1:0] tcnt;
`ifdef UART_CMD_RESP_CHECKSUM_EN
   logic [7:0]    csum;
   logic          second_pend;
   logic          rearm;
`endif

   // Packet decoder, register strobes, response sequencing and inter-byte timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         is_write    <= 1'b0;
         tcnt        <= '0;
         tx_vld      <= 1'b0;
         tx_data     <= 8'h00;
         reg_addr    <= '0;
         reg_wr_en   <= 1'b0;
         reg_wr_data <= 8'h00;
         reg_rd_en   <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
`ifdef UART_CMD_RESP_CHECKSUM_EN
         csum        <= 8'h00;
         second_pend <= 1'b0;
         rearm       <= 1'b0;
`endif
      end else begin
         // Strobes and error pulses last exactly one cycle
         reg_wr_en   <= 1'b0;
         reg_rd_en   <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  tcnt <= '0;
                  busy <= 1'b1;
`ifdef UART_CMD_RESP_CHECKSUM_EN
                  csum <= rx_data;
`endif
                  if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                     is_write <= (rx_data == OP_WRITE);
                     state    <= S_GET_ADDR;
                  end else begin
                     tx_data <= RSP_BAD;
                     tx_vld  <= 1'b1;
                     state   <= S_SEND;
                  end
               end
            end

            S_GET_ADDR: begin
               if (rx_valid) begin
                  tcnt     <= '0;
                  reg_addr <= rx_data[ADDR_BITS-1:0];
`ifdef UART_CMD_RESP_CHECKSUM_EN
                  csum     <= csum ^ rx_data;
                  state    <= is_write ? S_GET_DATA : S_GET_CSUM;
`else
                  if (is_write) begin
                     state <= S_GET_DATA;
                  end else begin
                     reg_rd_en <= 1'b1;
                     state     <= S_READ;
                  end
`endif
               end else if (tcnt == T_LAST) begin
                  tcnt        <= '0;
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            S_GET_DATA: begin
               if (rx_valid) begin
                  tcnt        <= '0;
                  reg_wr_data <= rx_data;
`ifdef UART_CMD_RESP_CHECKSUM_EN
                  csum        <= csum ^ rx_data;
                  state       <= S_GET_CSUM;
`else
                  reg_wr_en   <= 1'b1;
                  tx_data     <= RSP_ACK;
                  tx_vld      <= 1'b1;
                  state       <= S_SEND;
`endif
               end else if (tcnt == T_LAST) begin
                  tcnt        <= '0;
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

`ifdef UART_CMD_RESP_CHECKSUM_EN
            S_GET_CSUM: begin
               if (rx_valid) begin
                  tcnt <= '0;
                  if (rx_data != csum) begin
                     tx_data <= RSP_CSUM;
                     tx_vld  <= 1'b1;
                     state   <= S_SEND;
                  end else if (is_write) begin
                     reg_wr_en <= 1'b1;
                     tx_data   <= RSP_ACK;
                     tx_vld    <= 1'b1;
                     state     <= S_SEND;
                  end else begin
                     reg_rd_en <= 1'b1;
                     state     <= S_READ;
                  end
               end else if (tcnt == T_LAST) begin
                  tcnt        <= '0;
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
`endif

            S_READ: begin
               err_overrun <= rx_valid;
               state       <= S_CAPTURE;
            end

            S_CAPTURE: begin
               err_overrun <= rx_valid;
               tx_data     <= reg_rd_data;
               tx_vld      <= 1'b1;
               state       <= S_SEND;
`ifdef UART_CMD_RESP_CHECKSUM_EN
               second_pend <= 1'b1;
`endif
            end

            S_SEND: begin
               err_overrun <= rx_valid;
               if (tx_vld && tx_rdy) begin
                  tx_vld <= 1'b0;
`ifdef UART_CMD_RESP_CHECKSUM_EN
                  if (second_pend) begin
                     // Second read byte is the data XOR the read opcode
                     tx_data     <= tx_data ^ OP_READ;
                     second_pend <= 1'b0;
                     rearm       <= 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
`else
                  busy  <= 1'b0;
                  state <= S_IDLE;
`endif
               end
`ifdef UART_CMD_RESP_CHECKSUM_EN
               else if (rearm) begin
                  tx_vld <= 1'b1;
                  rearm  <= 1'b0;
               end
`endif
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
